// File: rtl/dff_snapshot_serializer.sv
// dff_snapshot_serializer: snapshots D on start and shifts it out MSB-first on sdo,
// holding each bit for BitCycles clocks, with frame/busy/done flags.
module dff_snapshot_serializer #(
    parameter int Width = 8,
    parameter int BitCycles = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [Width-1:0] D,
    input  logic             start,
    output logic             sdo,
    output logic             frame,
    output logic             busy,
    output logic             done
);
    localparam int BW = $clog2(Width + 1);
    localparam int PW = $clog2(BitCycles + 1);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t           state;
    logic [Width-1:0] sr;
    logic [Width-1:0] sr_shl;
    logic [BW-1:0]    bc;
    logic [PW-1:0]    pc;
    // Shifted value is formed separately so its MSB can be registered onto sdo even when Width=1
    assign sr_shl = sr << 1;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            sr    <= '0;
            bc    <= '0;
            pc    <= '0;
            sdo   <= 1'b0;
            frame <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    sr    <= D;
                    bc    <= BW'(Width - 1);
                    pc    <= PW'(BitCycles - 1);
                    sdo   <= D[Width-1];
                    frame <= 1'b1;
                    busy  <= 1'b1;
                    state <= SHIFT;
                end
                SHIFT: if (pc != '0) begin
                    pc <= pc - 1'b1;
                end else if (bc != '0) begin
                    sr  <= sr_shl;
                    sdo <= sr_shl[Width-1];
                    bc  <= bc - 1'b1;
                    pc  <= PW'(BitCycles - 1);
                end else begin
                    sdo   <= 1'b0;
                    frame <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dff_snapshot_serializer.sv
// tb_dff_snapshot_serializer: scoreboard bench for three serializer configurations
// (8x4, 1x1, 16x1) sharing clk and reset.
module tb_dff_snapshot_serializer;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [7:0] d8 = '0;
    logic [0:0] d1 = '0;
    logic [15:0] d16 = '0;
    logic st8 = 1'b0, st1 = 1'b0, st16 = 1'b0;
    logic sdo8, frame8, busy8, done8;
    logic sdo1, frame1, busy1, done1;
    logic sdo16, frame16, busy16, done16;
    logic m_sdo, m_frame, m_busy, m_done;
    int sel = 0;
    int checks = 0;
    int failures = 0;
    logic q[$];

    always #5 clk = ~clk;

    dff_snapshot_serializer #(.Width(8), .BitCycles(4)) u8 (
        .clk(clk), .reset(reset), .D(d8), .start(st8),
        .sdo(sdo8), .frame(frame8), .busy(busy8), .done(done8));
    dff_snapshot_serializer #(.Width(1), .BitCycles(1)) u1 (
        .clk(clk), .reset(reset), .D(d1), .start(st1),
        .sdo(sdo1), .frame(frame1), .busy(busy1), .done(done1));
    dff_snapshot_serializer #(.Width(16), .BitCycles(1)) u16 (
        .clk(clk), .reset(reset), .D(d16), .start(st16),
        .sdo(sdo16), .frame(frame16), .busy(busy16), .done(done16));

    assign m_sdo   = sel == 0 ? sdo8   : sel == 1 ? sdo1   : sdo16;
    assign m_frame = sel == 0 ? frame8 : sel == 1 ? frame1 : frame16;
    assign m_busy  = sel == 0 ? busy8  : sel == 1 ? busy1  : busy16;
    assign m_done  = sel == 0 ? done8  : sel == 1 ? done1  : done16;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_start(input int s, input logic v);
        st8  = (s == 0) ? v : 1'b0;
        st1  = (s == 1) ? v : 1'b0;
        st16 = (s == 2) ? v : 1'b0;
    endtask

    task automatic set_d(input int s, input logic [15:0] d);
        if (s == 0) d8 = d[7:0];
        else if (s == 1) d1 = d[0:0];
        else d16 = d;
    endtask

    task automatic idle_chk(input int n);
        for (int i = 0; i < n; i++) begin
            chk("idle", {sdo8, frame8, busy8, done8, sdo1, frame1, busy1, done1,
                         sdo16, frame16, busy16, done16}, 32'h0);
            @(negedge clk);
        end
    endtask

    // Called at a negedge; returns at the negedge after the done cycle (first IDLE cycle).
    task automatic run(input int s, input int w, input int bcy, input logic [15:0] d,
                       input bit mid, input bit dstart);
        sel = s;
        for (int k = w - 1; k >= 0; k--)
            for (int r = 0; r < bcy; r++) q.push_back(d[k]);
        set_d(s, d);
        set_start(s, 1'b1);
        @(negedge clk);
        set_start(s, 1'b0);
        for (int c = 0; c < w * bcy; c++) begin
            if (c == 0) set_d(s, 16'h0);
            set_start(s, mid && c == (w * bcy) / 2);
            chk("frame_hi", m_frame, 1);
            chk("busy_hi", m_busy, 1);
            chk("done_lo", m_done, 0);
            if (m_frame) begin
                if (q.size() > 0) chk("sdo", m_sdo, q.pop_front());
                else chk("sb_underflow", 1, 0);
            end
            @(negedge clk);
        end
        set_start(s, dstart);
        chk("done_pulse", {m_done, m_busy, m_frame, m_sdo}, 4'b1100);
        @(negedge clk);
        set_start(s, 1'b0);
        chk("after_done", {m_done, m_busy, m_frame, m_sdo}, 4'b0000);
        chk("sb_empty", q.size(), 0);
    endtask

    initial begin
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle_chk(20);
        run(0, 8, 4, 16'h00A5, 1'b0, 1'b0);
        run(0, 8, 4, 16'h00A5, 1'b1, 1'b1);
        idle_chk(3);
        run(0, 8, 4, 16'h005A, 1'b0, 1'b0);
        run(0, 8, 4, 16'h00C3, 1'b0, 1'b0);
        // Abort a frame in bit 3 with an asynchronous reset away from any clock edge
        d8 = 8'hFF;
        st8 = 1'b1;
        @(negedge clk);
        st8 = 1'b0;
        repeat (3 * 4 + 1) @(negedge clk);
        chk("pre_reset_frame", frame8, 1);
        #1 reset = 1'b1;
        #1 chk("async_reset", {sdo8, frame8, busy8, done8}, 4'b0000);
        @(negedge clk);
        reset = 1'b0;
        idle_chk(3);
        run(0, 8, 4, 16'h003C, 1'b0, 1'b0);
        run(1, 1, 1, 16'h0001, 1'b0, 1'b0);
        run(1, 1, 1, 16'h0000, 1'b0, 1'b0);
        run(2, 16, 1, 16'h8001, 1'b0, 1'b0);
        run(2, 16, 1, 16'h7FFE, 1'b0, 1'b0);
        idle_chk(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
